ssp_tx_fifo_param: RTL
======================

# ssp_tx_fifo_param

Parametrised transmit FIFO for the SSP block. It buffers words written by the processor over the APB-style write port and presents the oldest word to the SSP transmit logic, which pops it when a frame starts. It is the next-generation replacement for the fixed 8×4 transmit buffer. New over that buffer:
- width and depth are parameters
- exact occupancy output
- programmable watermark service request
- sticky overrun/underrun error flags
- pop path independent of PSEL

## Interface
- `DATA_W`, default 8: word width in bits.
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥2. `AW = $clog2(DEPTH)`.
- `PCLK`, input, 1: sole clock. All state changes on its rising edge.
- `CLEAR_B`, input, 1: reset, synchronous, active-low.
- `PSEL`, input, 1: processor select. Qualifies writes only.
- `PWRITE`, input, 1: processor write strobe. `push_req = PSEL & PWRITE`.
- `PWDATA`, input, DATA_W: word to enqueue.
- `LOGICWRITE`, input, 1: pop request from the transmit logic. Not gated by `PSEL`.
- `WMARK`, input, AW+1: watermark level, held static during operation.
- `ERR_CLR`, input, 1: clears the sticky error flags.
- `TxDATA`, output, DATA_W: head-of-queue word, `mem[rd_ptr]`.
- `EMPTY`, output, 1: `LEVEL == 0`.
- `FULL`, output, 1: `LEVEL == DEPTH`.
- `SSPTXINTR`, output, 1: equal to `FULL`. The processor must not write while it is high.
- `SSPTXWMINTR`, output, 1: `LEVEL <= WMARK`. Requests a refill.
- `LEVEL`, output, AW+1: current occupancy, 0..DEPTH.
- `OVERRUN`, output, 1: sticky. Set when a push was dropped.
- `UNDERRUN`, output, 1: sticky. Set when a pop was ignored.

## Operation
- State registers:
  - `wr_ptr` and `rd_ptr`, AW bits each, wrapping modulo DEPTH
  - `count`, AW+1 bits
  - `mem[DEPTH]`
  - the two error flags
- Reset (`CLEAR_B == 0` at an edge) overrides everything:
  - pointers = 0, `count` = 0, every `mem` entry = 0, `OVERRUN` = `UNDERRUN` = 0
  - resulting outputs: `TxDATA` = 0, `EMPTY` = 1, `FULL` = 0, `LEVEL` = 0, `SSPTXINTR` = 0, `SSPTXWMINTR` = 1
  - Reset mid-operation discards all queued words.
- Acceptance, evaluated on the pre-edge `count`:
  - `pop_ok = LOGICWRITE & (count != 0)`
  - `push_ok = push_req & ((count != DEPTH) | pop_ok)`
- `push_ok`: `mem[wr_ptr] <= PWDATA`, then `wr_ptr` increments.
- `pop_ok`: `rd_ptr` increments.
- `count` update: +1 for push only, −1 for pop only, unchanged for both or neither.
- Full with simultaneous push and pop: both are accepted, `LEVEL` stays at DEPTH, and `FULL` stays high.
- Empty with simultaneous push and pop: the push is accepted and the pop is ignored.
  - `UNDERRUN` sets.
  - There is no bypass: the new word appears on `TxDATA` after the edge and is not consumed.
- Push dropped (`push_req & !push_ok`): `OVERRUN` sets and the FIFO is unchanged.
- Pop on empty (`LOGICWRITE & count == 0`): `UNDERRUN` sets.
- Error flags:
  - `ERR_CLR` at an edge clears both flags.
  - If a new error event occurs on the same edge, set wins.
- Output derivation:
  - `EMPTY`, `FULL`, `SSPTXINTR`, `SSPTXWMINTR` and `LEVEL` decode combinationally from the registered `count` only. They are glitch-free with respect to inputs.
  - `TxDATA` is a combinational read of `mem[rd_ptr]`.
  - `TxDATA` is meaningless while `EMPTY` = 1, except that it reads 0 directly after reset.

## Timing
- Write latency: a word pushed at edge N is visible on `TxDATA` after edge N when the FIFO was empty before N. Otherwise it appears once all older words have been popped.
- Pop latency: a pop at edge N presents the next word on `TxDATA` after edge N, with zero extra cycles.
- Flags update on the same edge as the causing push/pop/reset.
- Sustained throughput: one push plus one pop per cycle, indefinitely, at any level from 1 to DEPTH.
- Pointer wrap: `DEPTH − 1 → 0` with no bubble. Ordering is preserved across the wrap.
- `PSEL = 0`: pushes are blocked, but `LOGICWRITE` pops still proceed.

## Test plan
1. Fill and drain (DATA_W=8, DEPTH=4, WMARK=1):
   - Reset, then push 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles.
   - `LEVEL` goes 1,2,3,4. `FULL` and `SSPTXINTR` rise after the 4th edge. `SSPTXWMINTR` falls after the 2nd edge.
   - Pop 4 times: `TxDATA` reads A1,B2,C3,D4, and `EMPTY` = 1 after the 4th pop.
2. Overflow:
   - From full, issue a 5th push of 0xEE with no pop.
   - `OVERRUN` = 1, `LEVEL` = 4, and the drain order is unchanged with no 0xEE.
   - `ERR_CLR` pulse: `OVERRUN` = 0 on the next edge.
3. Full with simultaneous push and pop:
   - From full [A1..D4], push 0x55 while popping.
   - `LEVEL` = 4, `OVERRUN` = 0, `TxDATA` = B2, and draining yields B2,C3,D4,55.
4. Empty with simultaneous push and pop:
   - After reset, push 0x3C while popping.
   - `LEVEL` = 1, `TxDATA` = 0x3C, `UNDERRUN` = 1.
5. Wrap-around streaming:
   - Push/pop every cycle for 20 cycles with incrementing data from a steady level of 2.
   - Output sequence equals input sequence delayed by 2 pops, and `LEVEL` stays at 2.
6. Reset mid-operation:
   - At level 3 with `OVERRUN` = 1, drive `CLEAR_B` = 0 for one edge together with a push.
   - Afterwards `LEVEL` = 0, `EMPTY` = 1, `OVERRUN` = 0, `TxDATA` = 0, and the push is discarded.

Source files
------------

// File: rtl/ssp_tx_fifo_param_if.sv
// Port bundle for the SSP transmit FIFO: processor write port, transmit-logic pop port and status.
// The master side drives requests. The slave side is the FIFO.
interface ssp_tx_fifo_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic              PSEL;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic              LOGICWRITE;
    logic [AW:0]       WMARK;
    logic              ERR_CLR;
    logic [DATA_W-1:0] TxDATA;
    logic              EMPTY;
    logic              FULL;
    logic              SSPTXINTR;
    logic              SSPTXWMINTR;
    logic [AW:0]       LEVEL;
    logic              OVERRUN;
    logic              UNDERRUN;

    modport master (
        output PSEL, PWRITE, PWDATA, LOGICWRITE, WMARK, ERR_CLR,
        input  TxDATA, EMPTY, FULL, SSPTXINTR, SSPTXWMINTR, LEVEL, OVERRUN, UNDERRUN
    );

    modport slave (
        input  PSEL, PWRITE, PWDATA, LOGICWRITE, WMARK, ERR_CLR,
        output TxDATA, EMPTY, FULL, SSPTXINTR, SSPTXWMINTR, LEVEL, OVERRUN, UNDERRUN
    );
endinterface

// File: rtl/ssp_tx_fifo_param.sv
// Parametrised SSP transmit FIFO with exact occupancy, watermark request and sticky error flags.
// Pops are driven by the transmit logic and are not qualified by PSEL.
module ssp_tx_fifo_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input logic                  PCLK,
    input logic                  CLEAR_B,
    ssp_tx_fifo_param_if.slave   bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overrun_q, overrun_d;
    logic              underrun_q, underrun_d;

    logic push_req;
    logic pop_ok;
    logic push_ok;

    // Acceptance uses the pre-edge count; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        push_req = bus.PSEL & bus.PWRITE;
        pop_ok   = bus.LOGICWRITE & (count_q != '0);
        push_ok  = push_req & ((count_q != DEPTH_C) | pop_ok);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = bus.PWDATA;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Error clear is applied first so that a coincident error event wins.
    always_comb begin
        overrun_d  = bus.ERR_CLR ? 1'b0 : overrun_q;
        underrun_d = bus.ERR_CLR ? 1'b0 : underrun_q;
        if (push_req && !push_ok) begin
            overrun_d = 1'b1;
        end
        if (bus.LOGICWRITE && (count_q == '0)) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        bus.TxDATA      = mem_q[rd_ptr_q];
        bus.LEVEL       = count_q;
        bus.EMPTY       = (count_q == '0);
        bus.FULL        = (count_q == DEPTH_C);
        bus.SSPTXINTR   = (count_q == DEPTH_C);
        bus.SSPTXWMINTR = (count_q <= bus.WMARK);
        bus.OVERRUN     = overrun_q;
        bus.UNDERRUN    = underrun_q;
    end
endmodule
